car_pwm_drv: RTL and testbench



---
 rtl/car_pwm_drv.sv | 188 ++++++++++++++++++
 tb/tb_car_pwm_drv.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/car_pwm_drv.sv
// Two-motor PWM drive stage: registered command, soft-start/soft-stop ramping and a dead period on reversal.
// Optional feature macro: CAR_PWM_BRAKE_EN (md pair = 11 brakes both bridge legs high instead of coasting).
module car_pwm_drv #(
  parameter int PRESCALE     = 4,
  parameter int PWM_BITS     = 8,
  parameter int DUTY_MAX     = 255,
  parameter int RAMP_STEP    = 16,
  parameter int DEAD_PERIODS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                md1,
  input  logic                md2,
  input  logic                md3,
  input  logic                md4,
  output logic                pwm_l_a,
  output logic                pwm_l_b,
  output logic                pwm_r_a,
  output logic                pwm_r_b,
  output logic [PWM_BITS-1:0] duty_l,
  output logic [PWM_BITS-1:0] duty_r
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DC_W = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
  localparam int DW   = PWM_BITS + 1;

  localparam logic [DW-1:0]       STEP  = DW'(RAMP_STEP);
  localparam logic [DW-1:0]       DMAX  = DW'(DUTY_MAX);
  localparam logic [PWM_BITS-1:0] FIRST = (RAMP_STEP > DUTY_MAX) ? PWM_BITS'(DUTY_MAX)
                                                                 : PWM_BITS'(RAMP_STEP);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN_FWD = 2'd1;
  localparam logic [1:0] S_RUN_REV = 2'd2;
  localparam logic [1:0] S_DEAD    = 2'd3;

  localparam logic [1:0] C_STOP  = 2'd0;
  localparam logic [1:0] C_FWD   = 2'd1;
  localparam logic [1:0] C_REV   = 2'd2;
  localparam logic [1:0] C_BRAKE = 2'd3;

  function automatic logic [1:0] decode(input logic fwd, input logic rev);
    logic [1:0] c;
    c = C_STOP;
    if (fwd && !rev) c = C_FWD;
    else if (rev && !fwd) c = C_REV;
`ifdef CAR_PWM_BRAKE_EN
    else if (fwd && rev) c = C_BRAKE;
`else
    else c = C_STOP;
`endif
    return c;
  endfunction

  function automatic logic [PWM_BITS-1:0] ramp_up(input logic [PWM_BITS-1:0] d);
    logic [DW-1:0] s;
    s = {1'b0, d} + STEP;
    return (s > DMAX) ? DMAX[PWM_BITS-1:0] : s[PWM_BITS-1:0];
  endfunction

  function automatic logic [PWM_BITS-1:0] ramp_dn(input logic [PWM_BITS-1:0] d);
    return ({1'b0, d} > STEP) ? (d - STEP[PWM_BITS-1:0]) : '0;
  endfunction

  logic [3:0]          cmd_q;
  logic [PS_W-1:0]     ps_q, ps_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                tick, period_end;

  logic [1:0]          cmd     [2];
  logic [1:0]          state_q [2], state_d [2];
  logic [PWM_BITS-1:0] duty_q  [2], duty_d  [2];
  logic [DC_W-1:0]     dead_q  [2], dead_d  [2];
  logic                brake_q [2], brake_d [2];
  logic                pwm_a_q [2], pwm_a_d [2];
  logic                pwm_b_q [2], pwm_b_d [2];

  assign cmd[0] = decode(cmd_q[0], cmd_q[1]);
  assign cmd[1] = decode(cmd_q[2], cmd_q[3]);

  assign tick       = (ps_q == PS_W'(PRESCALE - 1));
  assign period_end = tick && (pwm_cnt_q == '1);
  assign ps_d       = tick ? '0 : ps_q + PS_W'(1);
  assign pwm_cnt_d  = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;

  always_comb begin
    for (int m = 0; m < 2; m++) begin
      // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latch).
      state_d[m] = state_q[m];
      duty_d[m]  = duty_q[m];
      dead_d[m]  = dead_q[m];
      brake_d[m] = 1'b0;
      pwm_a_d[m] = brake_q[m] | ((state_q[m] == S_RUN_FWD) && (pwm_cnt_q < duty_q[m]));
      pwm_b_d[m] = brake_q[m] | ((state_q[m] == S_RUN_REV) && (pwm_cnt_q < duty_q[m]));

      if (cmd[m] == C_BRAKE) begin
        state_d[m] = S_IDLE;
        duty_d[m]  = '0;
        dead_d[m]  = '0;
        brake_d[m] = 1'b1;
      end else begin
        unique case (state_q[m])
          S_IDLE: begin
            if (cmd[m] == C_FWD) begin
              state_d[m] = S_RUN_FWD;
              duty_d[m]  = FIRST;
            end else if (cmd[m] == C_REV) begin
              state_d[m] = S_RUN_REV;
              duty_d[m]  = FIRST;
            end
          end
          S_RUN_FWD, S_RUN_REV: begin
            // Reversal clears drive at once; all other duty changes wait for period_end.
            if ((state_q[m] == S_RUN_FWD && cmd[m] == C_REV) ||
                (state_q[m] == S_RUN_REV && cmd[m] == C_FWD)) begin
              state_d[m] = S_DEAD;
              duty_d[m]  = '0;
              dead_d[m]  = '0;
            end else if (period_end) begin
              if (cmd[m] == C_STOP) begin
                duty_d[m] = ramp_dn(duty_q[m]);
                if (ramp_dn(duty_q[m]) == '0) state_d[m] = S_IDLE;
              end else begin
                duty_d[m] = ramp_up(duty_q[m]);
              end
            end
          end
          S_DEAD: begin
            if (period_end) begin
              if (dead_q[m] == DC_W'(DEAD_PERIODS - 1)) begin
                if (cmd[m] == C_FWD) begin
                  state_d[m] = S_RUN_FWD;
                  duty_d[m]  = FIRST;
                end else if (cmd[m] == C_REV) begin
                  state_d[m] = S_RUN_REV;
                  duty_d[m]  = FIRST;
                end else begin
                  state_d[m] = S_IDLE;
                end
              end else begin
                dead_d[m] = dead_q[m] + DC_W'(1);
              end
            end
          end
          default: state_d[m] = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      cmd_q     <= '0;
      ps_q      <= '0;
      pwm_cnt_q <= '0;
      for (int m = 0; m < 2; m++) begin
        state_q[m] <= S_IDLE;
        duty_q[m]  <= '0;
        dead_q[m]  <= '0;
        brake_q[m] <= 1'b0;
        pwm_a_q[m] <= 1'b0;
        pwm_b_q[m] <= 1'b0;
      end
    end else begin
      cmd_q     <= {md4, md3, md2, md1};
      ps_q      <= ps_d;
      pwm_cnt_q <= pwm_cnt_d;
      for (int m = 0; m < 2; m++) begin
        state_q[m] <= state_d[m];
        duty_q[m]  <= duty_d[m];
        dead_q[m]  <= dead_d[m];
        brake_q[m] <= brake_d[m];
        pwm_a_q[m] <= pwm_a_d[m];
        pwm_b_q[m] <= pwm_b_d[m];
      end
    end
  end

  assign pwm_l_a = pwm_a_q[0];
  assign pwm_l_b = pwm_b_q[0];
  assign pwm_r_a = pwm_a_q[1];
  assign pwm_r_b = pwm_b_q[1];
  assign duty_l  = duty_q[0];
  assign duty_r  = duty_q[1];

endmodule

// File: tb/tb_car_pwm_drv.sv
// Self-checking bench for car_pwm_drv: directed scenarios plus random md traffic against a behavioural model.
module tb_car_pwm_drv;

  localparam int PRESCALE     = 1;
  localparam int PWM_BITS     = 4;
  localparam int DUTY_MAX     = 12;
  localparam int RAMP_STEP    = 4;
  localparam int DEAD_PERIODS = 2;
  localparam int PERIOD       = PRESCALE * (1 << PWM_BITS);

  logic clk = 1'b0;
  logic reset, md1, md2, md3, md4;
  logic pwm_l_a, pwm_l_b, pwm_r_a, pwm_r_b;
  logic [PWM_BITS-1:0] duty_l, duty_r;

  int vectors = 0;
  int errors  = 0;

  // Behavioural model: 0 idle, 1 forward, 2 reverse, 3 dead; commands 0 stop, 1 fwd, 2 rev, 3 brake.
  int m_cmd [2];
  int m_st  [2];
  int m_duty[2];
  int m_dead[2];
  bit m_brk [2];
  bit m_a   [2];
  bit m_b   [2];
  int m_cnt;

  car_pwm_drv #(
    .PRESCALE(PRESCALE), .PWM_BITS(PWM_BITS), .DUTY_MAX(DUTY_MAX),
    .RAMP_STEP(RAMP_STEP), .DEAD_PERIODS(DEAD_PERIODS)
  ) dut (
    .clk(clk), .reset(reset),
    .md1(md1), .md2(md2), .md3(md3), .md4(md4),
    .pwm_l_a(pwm_l_a), .pwm_l_b(pwm_l_b), .pwm_r_a(pwm_r_a), .pwm_r_b(pwm_r_b),
    .duty_l(duty_l), .duty_r(duty_r)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int decode(input logic f, input logic r);
    if (f && !r) return 1;
    if (r && !f) return 2;
`ifdef CAR_PWM_BRAKE_EN
    if (f && r) return 3;
`endif
    return 0;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_edge();
    int  nst, nduty, ndead, c;
    bit  pe;
    if (reset) begin
      for (int m = 0; m < 2; m++) begin
        m_cmd[m] = 0; m_st[m] = 0; m_duty[m] = 0; m_dead[m] = 0;
        m_brk[m] = 0; m_a[m] = 0; m_b[m] = 0;
      end
      m_cnt = 0;
      return;
    end
    pe = (m_cnt == PERIOD - 1);
    for (int m = 0; m < 2; m++) begin
      m_a[m] = m_brk[m] || (m_st[m] == 1 && m_cnt < m_duty[m]);
      m_b[m] = m_brk[m] || (m_st[m] == 2 && m_cnt < m_duty[m]);
      nst = m_st[m]; nduty = m_duty[m]; ndead = m_dead[m];
      c = m_cmd[m];
      m_brk[m] = (c == 3);
      if (c == 3) begin
        nst = 0; nduty = 0; ndead = 0;
      end else if (m_st[m] == 0) begin
        if (c == 1 || c == 2) begin
          nst = c; nduty = imin(RAMP_STEP, DUTY_MAX);
        end
      end else if (m_st[m] == 1 || m_st[m] == 2) begin
        if (c != 0 && c != m_st[m]) begin
          nst = 3; nduty = 0; ndead = 0;
        end else if (pe) begin
          if (c == m_st[m]) nduty = imin(m_duty[m] + RAMP_STEP, DUTY_MAX);
          else begin
            nduty = imax(m_duty[m] - RAMP_STEP, 0);
            if (nduty == 0) nst = 0;
          end
        end
      end else if (pe) begin
        if (m_dead[m] == DEAD_PERIODS - 1) begin
          if (c == 1 || c == 2) begin
            nst = c; nduty = imin(RAMP_STEP, DUTY_MAX);
          end else nst = 0;
        end else ndead = m_dead[m] + 1;
      end
      m_st[m] = nst; m_duty[m] = nduty; m_dead[m] = ndead;
    end
    m_cmd[0] = decode(md1, md2);
    m_cmd[1] = decode(md3, md4);
    m_cnt = (m_cnt + 1) % PERIOD;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [11:0] act_vec();
    return {pwm_l_a, pwm_l_b, pwm_r_a, pwm_r_b, duty_l, duty_r};
  endfunction

  function automatic logic [11:0] exp_vec();
    return {m_a[0], m_b[0], m_a[1], m_b[1], 4'(m_duty[0]), 4'(m_duty[1])};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      {md4, md3, md2, md1} = 4'($urandom);
      cycle();
      vectors++;
      if (act_vec() !== 12'h000) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h expected 000", i, act_vec());
      end
    end
    {md4, md3, md2, md1} = 4'b0000;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      vectors++;
      if (act_vec() !== 12'h000) begin
        errors++;
        $display("FAIL reset_release[%0d]: got %h expected 000", i, act_vec());
      end
    end
  endtask

  task automatic test_ramp_up();
    int highs;
    int want[4] = '{4, 8, 12, 12};
    for (int i = 0; i < 2 * PERIOD && m_cnt != PERIOD - 2; i++) cycle();
    md1 = 1'b1; md3 = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    for (int p = 0; p < 4; p++) begin
      highs = 0;
      for (int i = 0; i < PERIOD; i++) begin
        vectors++;
        if (act_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL ramp_up p%0d c%0d: got %h expected %h", p, i, act_vec(), exp_vec());
        end
        if (pwm_l_a && pwm_r_a && !pwm_l_b && !pwm_r_b) highs++;
        cycle();
      end
      vectors++;
      if (highs != want[p]) begin
        errors++;
        $display("FAIL ramp_up_highs p%0d: got %0d expected %0d", p, highs, want[p]);
      end
    end
  endtask

  task automatic test_ramp_down();
    int seen[$];
    int last;
    last = 12;
    md1 = 1'b0;
    for (int i = 0; i < 4 * PERIOD; i++) begin
      cycle();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL ramp_down c%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
      if (int'(duty_l) != last) begin
        last = int'(duty_l);
        seen.push_back(last);
      end
    end
    vectors++;
    if (seen.size() != 3 || seen[0] != 8 || seen[1] != 4 || seen[2] != 0) begin
      errors++;
      $display("FAIL ramp_down_seq: got %p expected 8 4 0", seen);
    end
    vectors++;
    if (duty_r !== 4'd12 || pwm_l_a !== 1'b0 || pwm_l_b !== 1'b0) begin
      errors++;
      $display("FAIL ramp_down_end: got duty_r=%0d l_a=%b l_b=%b expected 12 0 0", duty_r, pwm_l_a, pwm_l_b);
    end
    md1 = 1'b1;
    for (int i = 0; i < 4 * PERIOD; i++) begin
      cycle();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL restart c%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reversal();
    int waited, highs;
    bit found;
    md1 = 1'b0; md2 = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    vectors++;
    if (pwm_l_a !== 1'b0 || pwm_l_b !== 1'b0 || duty_l !== 4'd0) begin
      errors++;
      $display("FAIL reversal_cut: got a=%b b=%b duty=%0d expected 0 0 0", pwm_l_a, pwm_l_b, duty_l);
    end
    waited = 0; found = 0;
    while (!found && waited < 5 * PERIOD) begin
      vectors++;
      if (act_vec() !== exp_vec() || pwm_l_a !== 1'b0) begin
        errors++;
        $display("FAIL reversal_dead w%0d: got %h expected %h", waited, act_vec(), exp_vec());
      end
      if (pwm_l_b) found = 1;
      else begin
        cycle();
        waited++;
      end
    end
    vectors++;
    if (!found || waited < PERIOD) begin
      errors++;
      $display("FAIL reversal_dead_len: got found=%0d waited=%0d expected 1 and >=%0d", found, waited, PERIOD);
    end
    highs = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (pwm_l_b && !pwm_l_a) highs++;
      cycle();
    end
    vectors++;
    if (highs != 4) begin
      errors++;
      $display("FAIL reversal_first_period: got %0d high expected 4", highs);
    end
  endtask

  task automatic test_both_cmd();
    md1 = 1'b1; md2 = 1'b0;
    for (int i = 0; i < 7 * PERIOD; i++) begin
      cycle();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL refwd c%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
    vectors++;
    if (duty_l !== 4'd12) begin
      errors++;
      $display("FAIL refwd_duty: got %0d expected 12", duty_l);
    end
    md2 = 1'b1;
`ifdef CAR_PWM_BRAKE_EN
    for (int i = 0; i < 3; i++) cycle();
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (pwm_l_a !== 1'b1 || pwm_l_b !== 1'b1 || duty_l !== 4'd0 || act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL brake c%0d: got %h expected a=b=1 duty 0 (%h)", i, act_vec(), exp_vec());
      end
      cycle();
    end
`else
    begin
      int seen[$];
      int last;
      last = 12;
      for (int i = 0; i < 4 * PERIOD; i++) begin
        cycle();
        vectors++;
        if (act_vec() !== exp_vec() || (pwm_l_a && pwm_l_b)) begin
          errors++;
          $display("FAIL coast c%0d: got %h expected %h", i, act_vec(), exp_vec());
        end
        if (int'(duty_l) != last) begin
          last = int'(duty_l);
          seen.push_back(last);
        end
      end
      vectors++;
      if (seen.size() != 3 || seen[0] != 8 || seen[1] != 4 || seen[2] != 0) begin
        errors++;
        $display("FAIL coast_seq: got %p expected 8 4 0", seen);
      end
    end
`endif
    md1 = 1'b0; md2 = 1'b0;
    for (int i = 0; i < 4 * PERIOD; i++) cycle();
  endtask

  task automatic test_reset_mid_run();
    int n;
    bit found;
    md1 = 1'b1;
    n = 0;
    while (duty_l !== 4'd8 && n < 4 * PERIOD) begin
      cycle();
      n++;
    end
    vectors++;
    if (duty_l !== 4'd8) begin
      errors++;
      $display("FAIL midrst_reach8: got %0d expected 8", duty_l);
    end
    reset = 1'b1;
    cycle();
    vectors++;
    if (act_vec() !== 12'h000) begin
      errors++;
      $display("FAIL midrst_clear: got %h expected 000", act_vec());
    end
    reset = 1'b0;
    n = 0; found = 0;
    while (!found && n < 3 * PERIOD) begin
      cycle();
      n++;
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL midrst_run c%0d: got %h expected %h", n, act_vec(), exp_vec());
      end
      if (pwm_l_a) found = 1;
    end
    vectors++;
    if (!found || duty_l !== 4'd4) begin
      errors++;
      $display("FAIL midrst_first_duty: got found=%0d duty=%0d expected 1 4", found, duty_l);
    end
  endtask

  task automatic test_random();
    int hold;
    for (int s = 0; s < 80; s++) begin
      {md4, md3, md2, md1} = 4'($urandom);
      reset = ($urandom_range(0, 29) == 0);
      hold = $urandom_range(1, 40);
      for (int i = 0; i < hold; i++) begin
        cycle();
        reset = 1'b0;
        vectors++;
        if (act_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL random s%0d c%0d: got %h expected %h", s, i, act_vec(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    {md4, md3, md2, md1} = 4'b0000;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_reversal();
    test_both_cmd();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
